// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and helpers for the 4-way memory port arbiter
package arb_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Binary index of the set bit of a one-hot 4-bit vector (0 when none set).
  function automatic logic [1:0] onehot4_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // One-hot 4-bit vector with only bit idx set.
  function automatic logic [3:0] idx_to_onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational 4-way winner picker, rotating or fixed priority
module rr_pick4
  import arb_pkg::*;
(
  input  logic [3:0] req,
  input  logic [3:0] mask,
  input  logic [1:0] last,
  input  logic       rr_en,
  output logic       any,
  output logic [1:0] idx
);

  logic [3:0] eligible;
  logic [1:0] cand;

  assign eligible = req & ~mask;

  // Walk candidates in priority order (last+1..last+4, or 0..3); first eligible wins.
  always_comb begin
    any  = 1'b0;
    idx  = 2'd0;
    cand = 2'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = rr_en ? (last + 2'(k + 1)) : 2'(k);
      if (!any && eligible[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter4.sv
// rtl/mem_port_arbiter4.sv - shares one memory port among 4 requesters with held grants
module mem_port_arbiter4
  import arb_pkg::*;
#(
  parameter int ROUND_ROBIN = 1,
  parameter int MAX_WAIT    = 0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       mem_valid,
  input  logic       mem_ready,
  output logic [3:0] done,
  output logic       timeout,
  output logic       busy
);

  // wait_cnt only ever needs to reach MAX_WAIT-1; with no limit it just saturates.
  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT =
    (MAX_WAIT > 0) ? WAIT_W'(MAX_WAIT - 1) : {WAIT_W{1'b1}};
  localparam logic TIMEOUT_EN = (MAX_WAIT > 0);
  localparam logic RR_EN      = (ROUND_ROBIN != 0);

  arb_state_t        state, state_next;
  logic [3:0]        gnt_next;
  logic [1:0]        sel_next;
  logic [1:0]        last_winner, last_next;
  logic [WAIT_W-1:0] wait_cnt, wait_next;
  logic [3:0]        done_next;
  logic              timeout_next;

  logic [3:0]        pick_mask;
  logic [1:0]        pick_last;
  logic              pick_any;
  logic [1:0]        pick_idx;
  logic              abort;
  logic              finish;

  // While idle everyone is eligible from last_winner onward; while busy the
  // current owner is masked so a completion hands over to someone else first.
  always_comb begin
    pick_mask = 4'b0000;
    pick_last = last_winner;
    if (state == ARB_BUSY) begin
      pick_mask = gnt;
      pick_last = sel;
    end
  end

  rr_pick4 u_pick (
    .req   (req),
    .mask  (pick_mask),
    .last  (pick_last),
    .rr_en (RR_EN),
    .any   (pick_any),
    .idx   (pick_idx)
  );

  // A ready in the last allowed wait cycle is a normal completion, not an abort.
  assign abort  = TIMEOUT_EN && (state == ARB_BUSY) && !mem_ready && (wait_cnt == WAIT_LIMIT);
  assign finish = (state == ARB_BUSY) && (mem_ready || abort);

  // Next-state and next-register values for grant, wait counter and pulses.
  always_comb begin
    state_next   = state;
    gnt_next     = gnt;
    sel_next     = sel;
    last_next    = last_winner;
    wait_next    = wait_cnt;
    done_next    = 4'b0000;
    timeout_next = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (pick_any) begin
          state_next = ARB_BUSY;
          gnt_next   = idx_to_onehot4(pick_idx);
          sel_next   = pick_idx;
          wait_next  = '0;
        end
      end
      ARB_BUSY: begin
        if (finish) begin
          done_next    = gnt;
          timeout_next = abort;
          last_next    = onehot4_to_idx(gnt);
          wait_next    = '0;
          if (pick_any) begin
            gnt_next = idx_to_onehot4(pick_idx);
            sel_next = pick_idx;
          end else begin
            gnt_next   = 4'b0000;
            state_next = ARB_IDLE;
          end
        end else if (wait_cnt != {WAIT_W{1'b1}}) begin
          wait_next = wait_cnt + WAIT_W'(1);
        end
      end
      default: begin
        state_next = ARB_IDLE;
        gnt_next   = 4'b0000;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Grant, select, rotation pointer, wait counter and completion pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gnt         <= 4'b0000;
      sel         <= 2'd0;
      last_winner <= 2'd3;
      wait_cnt    <= '0;
      done        <= 4'b0000;
      timeout     <= 1'b0;
    end else begin
      gnt         <= gnt_next;
      sel         <= sel_next;
      last_winner <= last_next;
      wait_cnt    <= wait_next;
      done        <= done_next;
      timeout     <= timeout_next;
    end
  end

  assign mem_valid = |gnt;
  assign busy      = (state == ARB_BUSY);

endmodule

// File: tb/tb_mem_port_arbiter4.sv
// tb/tb_mem_port_arbiter4.sv - self-checking bench for mem_port_arbiter4
module tb_mem_port_arbiter4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] req[3];
  logic       mem_ready[3];
  logic [3:0] gnt[3];
  logic [1:0] sel[3];
  logic       mem_valid[3];
  logic [3:0] done[3];
  logic       timeout[3];
  logic       busy[3];

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  // Instance 0: round robin, no limit. 1: fixed priority. 2: round robin, MAX_WAIT=4.
  mem_port_arbiter4 #(.ROUND_ROBIN(1), .MAX_WAIT(0)) dut_rr (
    .clock(clock), .reset_n(reset_n), .req(req[0]), .gnt(gnt[0]), .sel(sel[0]),
    .mem_valid(mem_valid[0]), .mem_ready(mem_ready[0]), .done(done[0]),
    .timeout(timeout[0]), .busy(busy[0]));

  mem_port_arbiter4 #(.ROUND_ROBIN(0), .MAX_WAIT(0)) dut_fp (
    .clock(clock), .reset_n(reset_n), .req(req[1]), .gnt(gnt[1]), .sel(sel[1]),
    .mem_valid(mem_valid[1]), .mem_ready(mem_ready[1]), .done(done[1]),
    .timeout(timeout[1]), .busy(busy[1]));

  mem_port_arbiter4 #(.ROUND_ROBIN(1), .MAX_WAIT(4)) dut_to (
    .clock(clock), .reset_n(reset_n), .req(req[2]), .gnt(gnt[2]), .sel(sel[2]),
    .mem_valid(mem_valid[2]), .mem_ready(mem_ready[2]), .done(done[2]),
    .timeout(timeout[2]), .busy(busy[2]));

  // Reference model: owner index (-1 idle), last winner, cycles waited.
  int         m_owner[3];
  int         m_last[3];
  int         m_wait[3];
  logic [1:0] m_sel[3];
  logic [3:0] m_done[3];
  logic       m_to[3];

  function automatic bit cfg_rr(input int i);
    return (i != 1);
  endfunction

  function automatic int cfg_mw(input int i);
    return (i == 2) ? 4 : 0;
  endfunction

  function automatic int pick(input int i, input logic [3:0] r, input int masked, input int last);
    int c;
    for (int k = 1; k <= 4; k++) begin
      c = cfg_rr(i) ? (last + k) % 4 : k - 1;
      if (r[c] && c != masked) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_owner[i] = -1;
      m_last[i]  = 3;
      m_wait[i]  = 0;
      m_sel[i]   = 2'd0;
      m_done[i]  = 4'b0;
      m_to[i]    = 1'b0;
    end
  endtask

  task automatic model_step(input int i);
    int   w;
    logic ab;
    m_done[i] = 4'b0;
    m_to[i]   = 1'b0;
    if (m_owner[i] < 0) begin
      w = pick(i, req[i], -1, m_last[i]);
      if (w >= 0) begin
        m_owner[i] = w;
        m_sel[i]   = 2'(w);
        m_wait[i]  = 0;
      end
    end else begin
      ab = (cfg_mw(i) > 0) && (m_wait[i] == cfg_mw(i) - 1) && !mem_ready[i];
      if (mem_ready[i] || ab) begin
        m_done[i] = 4'(1 << m_owner[i]);
        m_to[i]   = ab;
        m_last[i] = m_owner[i];
        m_wait[i] = 0;
        w = pick(i, req[i], m_owner[i], m_last[i]);
        m_owner[i] = w;
        if (w >= 0) m_sel[i] = 2'(w);
      end else begin
        m_wait[i]++;
      end
    end
  endtask

  function automatic logic [12:0] exp_vec(input int i);
    logic [3:0] g;
    g = (m_owner[i] >= 0) ? 4'(1 << m_owner[i]) : 4'b0;
    return {g, m_sel[i], (m_owner[i] >= 0), m_done[i], m_to[i], (m_owner[i] >= 0)};
  endfunction

  function automatic logic [12:0] obs_vec(input int i);
    return {gnt[i], sel[i], mem_valid[i], done[i], timeout[i], busy[i]};
  endfunction

  task automatic tick();
    @(posedge clock);
    for (int i = 0; i < 3; i++) model_step(i);
    #1;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) begin
      req[i] = 4'b0;
      mem_ready[i] = 1'b0;
    end
    reset_n = 1'b0;
    #3;
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      req[i] = 4'b0;
      mem_ready[i] = 1'b0;
    end
    reset_n = 1'b0;
    model_reset();
    #2;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs_vec(i) !== 13'b0) begin
        bad++;
        $display("FAIL reset inst%0d: got %b want %b", i, obs_vec(i), 13'b0);
      end
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    req[0] = 4'b0001;
    tick();
    total++;
    if (gnt[0] !== 4'b0001 || sel[0] !== 2'd0 || mem_valid[0] !== 1'b1 || busy[0] !== 1'b1) begin
      bad++;
      $display("FAIL single_grant: gnt=%b sel=%0d mv=%b busy=%b want 0001 0 1 1", gnt[0], sel[0], mem_valid[0], busy[0]);
    end
    tick();
    total++;
    if (gnt[0] !== 4'b0001 || done[0] !== 4'b0000) begin
      bad++;
      $display("FAIL single_hold: gnt=%b done=%b want 0001 0000", gnt[0], done[0]);
    end
    mem_ready[0] = 1'b1;
    tick();
    total++;
    if (done[0] !== 4'b0001 || gnt[0] !== 4'b0000 || mem_valid[0] !== 1'b0) begin
      bad++;
      $display("FAIL single_done: done=%b gnt=%b mv=%b want 0001 0000 0", done[0], gnt[0], mem_valid[0]);
    end
    req[0] = 4'b0;
    mem_ready[0] = 1'b0;
    tick();
    total++;
    if (done[0] !== 4'b0000 || busy[0] !== 1'b0 || sel[0] !== 2'd0) begin
      bad++;
      $display("FAIL single_idle: done=%b busy=%b sel=%0d want 0000 0 0", done[0], busy[0], sel[0]);
    end
  endtask

  task automatic test_rr_order();
    int order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    req[0] = 4'b1111;
    mem_ready[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if (gnt[0] !== 4'(1 << order[k]) || sel[0] !== 2'(order[k]) || mem_valid[0] !== 1'b1) begin
        bad++;
        $display("FAIL rr_order step%0d: gnt=%b sel=%0d mv=%b want gnt idx %0d", k, gnt[0], sel[0], mem_valid[0], order[k]);
      end
      if (k > 0) begin
        total++;
        if (done[0] !== 4'(1 << order[k-1])) begin
          bad++;
          $display("FAIL rr_done step%0d: done=%b want idx %0d", k, done[0], order[k-1]);
        end
      end
    end
    req[0] = 4'b0;
    tick();
    mem_ready[0] = 1'b0;
    total++;
    if (obs_vec(0) !== exp_vec(0)) begin
      bad++;
      $display("FAIL rr_drain: got %b want %b", obs_vec(0), exp_vec(0));
    end
  endtask

  task automatic test_fixed();
    int order[4] = '{1, 2, 1, 2};
    do_reset();
    req[1] = 4'b1110;
    mem_ready[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (gnt[1] !== 4'(1 << order[k]) || sel[1] !== 2'(order[k])) begin
        bad++;
        $display("FAIL fixed_order step%0d: gnt=%b sel=%0d want idx %0d", k, gnt[1], sel[1], order[k]);
      end
    end
    req[1] = 4'b0;
    mem_ready[1] = 1'b0;
  endtask

  task automatic test_drop();
    do_reset();
    req[0] = 4'b0100;
    tick();
    req[0] = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (gnt[0] !== 4'b0100 || sel[0] !== 2'd2 || done[0] !== 4'b0000) begin
        bad++;
        $display("FAIL drop_hold cyc%0d: gnt=%b sel=%0d done=%b want 0100 2 0000", k, gnt[0], sel[0], done[0]);
      end
    end
    mem_ready[0] = 1'b1;
    tick();
    total++;
    if (done[0] !== 4'b0100 || gnt[0] !== 4'b0000 || sel[0] !== 2'd2) begin
      bad++;
      $display("FAIL drop_done: done=%b gnt=%b sel=%0d want 0100 0000 2", done[0], gnt[0], sel[0]);
    end
    mem_ready[0] = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    req[2] = 4'b0011;
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (gnt[2] !== 4'b0001 || timeout[2] !== 1'b0 || done[2] !== 4'b0000) begin
        bad++;
        $display("FAIL to_wait cyc%0d: gnt=%b to=%b done=%b want 0001 0 0000", k, gnt[2], timeout[2], done[2]);
      end
    end
    tick();
    total++;
    if (timeout[2] !== 1'b1 || done[2] !== 4'b0001 || gnt[2] !== 4'b0010 || mem_valid[2] !== 1'b1) begin
      bad++;
      $display("FAIL to_abort: to=%b done=%b gnt=%b mv=%b want 1 0001 0010 1", timeout[2], done[2], gnt[2], mem_valid[2]);
    end
    req[2] = 4'b0010;
    for (int k = 0; k < 3; k++) tick();
    mem_ready[2] = 1'b1;
    tick();
    total++;
    if (timeout[2] !== 1'b0 || done[2] !== 4'b0010 || gnt[2] !== 4'b0000) begin
      bad++;
      $display("FAIL to_ready_wins: to=%b done=%b gnt=%b want 0 0010 0000", timeout[2], done[2], gnt[2]);
    end
    req[2] = 4'b0;
    mem_ready[2] = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    req[0] = 4'b0100;
    tick();
    total++;
    if (gnt[0] !== 4'b0100) begin
      bad++;
      $display("FAIL areset_pre: gnt=%b want 0100", gnt[0]);
    end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (gnt[0] !== 4'b0000 || mem_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
      bad++;
      $display("FAIL areset_now: gnt=%b mv=%b busy=%b want 0000 0 0", gnt[0], mem_valid[0], busy[0]);
    end
    model_reset();
    mem_ready[0] = 1'b1;
    @(posedge clock);
    #1;
    total++;
    if (done[0] !== 4'b0000 || gnt[0] !== 4'b0000) begin
      bad++;
      $display("FAIL areset_nodone: done=%b gnt=%b want 0000 0000", done[0], gnt[0]);
    end
    mem_ready[0] = 1'b0;
    #2;
    reset_n = 1'b1;
    req[0] = 4'b0101;
    tick();
    total++;
    if (gnt[0] !== 4'b0001 || sel[0] !== 2'd0) begin
      bad++;
      $display("FAIL areset_restart: gnt=%b sel=%0d want 0001 0", gnt[0], sel[0]);
    end
    req[0] = 4'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3; i++) begin
      do_reset();
      for (int c = 0; c < 300; c++) begin
        req[i] = (req[i] & ~m_done[i]) | (4'($urandom) & 4'($urandom));
        mem_ready[i] = ($urandom_range(0, 2) == 0);
        tick();
        total++;
        if (obs_vec(i) !== exp_vec(i)) begin
          bad++;
          $display("FAIL random inst%0d cyc%0d: got %b want %b", i, c, obs_vec(i), exp_vec(i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_order();
    test_fixed();
    test_drop();
    test_timeout();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
